differentiator: RTL and testbench

Modular first-difference (comb) stage: registers y[n] = x[n] − x[n−p_DELAY] over a qualified sample stream. It is the inverse of the wrapping accumulator in the arithmetic library. An accumulator output fed through this block with p_DELAY = 1 reproduces the original summand stream exactly, including across overflow wrap. It sits downstream of integrator stages (CIC decimator comb section, rate/delta recovery from running totals).

---
 rtl/differentiator_pkg.sv | 27 ++
 rtl/differentiator_delay_line.sv | 49 ++++
 rtl/differentiator.sv | 98 +++++++++
 tb/tb_differentiator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/differentiator_pkg.sv
// Shared arithmetic helpers for the differentiator: constant clog2 and derived widths.
package differentiator_pkg;

    // Ceiling log2 for elaboration-time width calculations; clog2(0) = clog2(1) = 0.
    function automatic int unsigned f_clog2(input int unsigned value);
        int unsigned result;
        int unsigned remaining;
        result    = 0;
        remaining = (value > 0) ? value - 1 : 0;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Pointer width addressing `depth` entries, never narrower than one bit.
    function automatic int unsigned f_ptr_width(input int unsigned depth);
        return (f_clog2(depth) < 1) ? 1 : f_clog2(depth);
    endfunction

    // Counter width able to hold the value `depth` itself (saturating fill count).
    function automatic int unsigned f_count_width(input int unsigned depth);
        return (f_clog2(depth + 1) < 1) ? 1 : f_clog2(depth + 1);
    endfunction

endpackage : differentiator_pkg

// File: rtl/differentiator_delay_line.sv
// Circular history buffer of p_DEPTH samples; o_OLDEST is the entry about to be overwritten.
module delay_line
    import differentiator_pkg::*;
#(
    parameter int unsigned p_DATA_WIDTH = 8,
    parameter int unsigned p_DEPTH      = 1
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic                    i_CLK_EN,
    input  logic                    i_WR,
    input  logic [p_DATA_WIDTH-1:0] i_DATA,
    output logic [p_DATA_WIDTH-1:0] o_OLDEST
);

    localparam int unsigned PTR_W = f_ptr_width(p_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(p_DEPTH - 1);

    logic [p_DATA_WIDTH-1:0] mem_q [p_DEPTH];
    logic [p_DATA_WIDTH-1:0] mem_d [p_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        wr_ptr_d;
    logic                    write_en;

    assign write_en = i_CLK_EN & i_WR;

    // Read side sees the old entry; the write lands on the clock edge.
    assign o_OLDEST = mem_q[wr_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (write_en) begin
            mem_d[wr_ptr_q] = i_DATA;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

endmodule : delay_line

// File: rtl/differentiator.sv
// Modular first-difference stage: y[n] = x[n] - x[n-p_DELAY], registered, with primed flag.
module differentiator
    import differentiator_pkg::*;
#(
    parameter int unsigned p_DATA_WIDTH = 8,
    parameter int unsigned p_DELAY      = 1
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic                    i_CLK_EN,
    input  logic                    i_VALID,
    input  logic [p_DATA_WIDTH-1:0] i_SAMPLE,
    output logic                    o_VALID,
    output logic [p_DATA_WIDTH-1:0] o_DIFFERENCE,
    output logic                    o_PRIMED
);

    localparam int unsigned CNT_W = f_count_width(p_DELAY);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(p_DELAY);

    logic                    accept;
    logic [p_DATA_WIDTH-1:0] oldest;

    logic [p_DATA_WIDTH-1:0] diff_q,   diff_d;
    logic                    valid_q,  valid_d;
    logic                    primed_q, primed_d;
    logic [CNT_W-1:0]        fill_q,   fill_d;

    assign accept = i_CLK_EN & i_VALID;

    delay_line #(
        .p_DATA_WIDTH (p_DATA_WIDTH),
        .p_DEPTH      (p_DELAY)
    ) u_delay_line (
        .i_CLK    (i_CLK),
        .i_RST    (i_RST),
        .i_CLK_EN (i_CLK_EN),
        .i_WR     (i_VALID),
        .i_DATA   (i_SAMPLE),
        .o_OLDEST (oldest)
    );

    // Disabled cycles hold everything, so a valid pulse stretches across them.
    always_comb begin
        diff_d   = diff_q;
        valid_d  = valid_q;
        primed_d = primed_q;
        fill_d   = fill_q;
        if (i_CLK_EN) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            diff_d   = i_SAMPLE - oldest;
            valid_d  = 1'b1;
            fill_d   = (fill_q == FULL_CNT) ? fill_q : fill_q + CNT_W'(1);
            primed_d = (fill_d == FULL_CNT);
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            diff_q   <= '0;
            valid_q  <= 1'b0;
            primed_q <= 1'b0;
            fill_q   <= '0;
        end else begin
            diff_q   <= diff_d;
            valid_q  <= valid_d;
            primed_q <= primed_d;
            fill_q   <= fill_d;
        end
    end

    assign o_DIFFERENCE = diff_q;
    assign o_VALID      = valid_q;
    assign o_PRIMED     = primed_q;

`ifdef FORMAL
    logic f_past_valid = 1'b0;

    always_ff @(posedge i_CLK) begin
        f_past_valid <= 1'b1;
        if (f_past_valid) begin
            if ($past(i_RST)) begin
                assert (o_DIFFERENCE == '0 && !o_VALID && !o_PRIMED);
            end else if ($past(accept)) begin
                assert (o_DIFFERENCE == p_DATA_WIDTH'($past(i_SAMPLE) - $past(oldest)));
                assert (o_VALID);
            end else if (!$past(i_CLK_EN)) begin
                assert (o_DIFFERENCE == $past(o_DIFFERENCE));
                assert (o_VALID == $past(o_VALID));
                assert (o_PRIMED == $past(o_PRIMED));
            end
        end
    end
`endif

endmodule : differentiator

// File: tb/tb_differentiator.sv
// Directed bench for differentiator: one instance with D = 1, one with D = 3, shared stimulus.
module tb_differentiator;

    logic       clk;
    logic       rst;
    logic       clk_en;
    logic       valid_in;
    logic [7:0] sample;

    logic       d1_valid;
    logic [7:0] d1_diff;
    logic       d1_primed;
    logic       d3_valid;
    logic [7:0] d3_diff;
    logic       d3_primed;

    int unsigned n_tests;
    int unsigned n_fail;

    differentiator #(.p_DATA_WIDTH(8), .p_DELAY(1)) u_dut_d1 (
        .i_CLK        (clk),
        .i_RST        (rst),
        .i_CLK_EN     (clk_en),
        .i_VALID      (valid_in),
        .i_SAMPLE     (sample),
        .o_VALID      (d1_valid),
        .o_DIFFERENCE (d1_diff),
        .o_PRIMED     (d1_primed)
    );

    differentiator #(.p_DATA_WIDTH(8), .p_DELAY(3)) u_dut_d3 (
        .i_CLK        (clk),
        .i_RST        (rst),
        .i_CLK_EN     (clk_en),
        .i_VALID      (valid_in),
        .i_SAMPLE     (sample),
        .o_VALID      (d3_valid),
        .o_DIFFERENCE (d3_diff),
        .o_PRIMED     (d3_primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        clk_en   = 1'b1;
        valid_in = 1'b0;
        sample   = 8'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic accept(input logic [7:0] value);
        clk_en   = 1'b1;
        valid_in = 1'b1;
        sample   = value;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic idle();
        clk_en   = 1'b1;
        valid_in = 1'b0;
        tick();
    endtask

    logic [7:0] d1_stream [4];
    logic [7:0] d1_expect [4];
    logic [7:0] d3_stream [6];
    logic [7:0] d3_expect [6];
    logic [7:0] acc;
    logic [7:0] summands  [3];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        d1_stream = '{8'd5, 8'd9, 8'd9, 8'd2};
        d1_expect = '{8'd5, 8'd4, 8'd0, 8'hF9};
        d3_stream = '{8'd1, 8'd2, 8'd3, 8'd10, 8'd20, 8'd30};
        d3_expect = '{8'd1, 8'd2, 8'd3, 8'd9, 8'd18, 8'd27};
        summands  = '{8'd200, 8'd100, 8'd50};

        // Reset state
        do_reset();
        check("rst_diff", 32'(d1_diff), 32'd0);
        check("rst_valid", 32'(d1_valid), 32'd0);
        check("rst_primed", 32'(d1_primed), 32'd0);
        check("rst_primed_d3", 32'(d3_primed), 32'd0);

        // Basic D = 1 stream with modular wrap on the last sample
        for (int i = 0; i < 4; i++) begin
            accept(d1_stream[i]);
            check($sformatf("d1_diff[%0d]", i), 32'(d1_diff), 32'(d1_expect[i]));
            check($sformatf("d1_valid[%0d]", i), 32'(d1_valid), 32'd1);
            check($sformatf("d1_primed[%0d]", i), 32'(d1_primed), 32'd1);
        end
        idle();
        check("d1_idle_valid", 32'(d1_valid), 32'd0);
        check("d1_idle_hold", 32'(d1_diff), 32'hF9);

        // Accumulator -> differentiator: running totals 200, 44, 94 recover the summands
        do_reset();
        acc = 8'd0;
        for (int i = 0; i < 3; i++) begin
            acc = acc + summands[i];
            accept(acc);
            check($sformatf("chain[%0d]", i), 32'(d1_diff), 32'(summands[i]));
        end

        // D = 3 stream, primed on the third output
        do_reset();
        for (int i = 0; i < 6; i++) begin
            accept(d3_stream[i]);
            check($sformatf("d3_diff[%0d]", i), 32'(d3_diff), 32'(d3_expect[i]));
            check($sformatf("d3_primed[%0d]", i), 32'(d3_primed), (i >= 2) ? 32'd1 : 32'd0);
        end

        // Clock-enable gap: outputs and the valid pulse freeze
        do_reset();
        accept(8'd7);
        check("en_first", 32'(d1_diff), 32'd7);
        for (int i = 0; i < 4; i++) begin
            clk_en   = 1'b0;
            valid_in = 1'b1;
            sample   = 8'd99;
            tick();
            check($sformatf("en_gap_valid[%0d]", i), 32'(d1_valid), 32'd1);
            check($sformatf("en_gap_diff[%0d]", i), 32'(d1_diff), 32'd7);
        end
        accept(8'd12);
        check("en_after", 32'(d1_diff), 32'd5);
        check("en_after_valid", 32'(d1_valid), 32'd1);

        // Valid gaps do not advance history
        do_reset();
        accept(8'd4);
        check("gap_first", 32'(d1_diff), 32'd4);
        for (int i = 0; i < 3; i++) begin
            idle();
            check($sformatf("gap_valid[%0d]", i), 32'(d1_valid), 32'd0);
            check($sformatf("gap_primed[%0d]", i), 32'(d1_primed), 32'd1);
        end
        accept(8'd10);
        check("gap_after", 32'(d1_diff), 32'd6);
        check("gap_after_d3", 32'(d3_diff), 32'd10);

        // Mid-stream reset with a sample presented: dropped, history cleared
        do_reset();
        accept(8'd30);
        accept(8'd40);
        accept(8'd45);
        check("pre_rst_d3_primed", 32'(d3_primed), 32'd1);
        rst      = 1'b1;
        clk_en   = 1'b1;
        valid_in = 1'b1;
        sample   = 8'd50;
        tick();
        rst      = 1'b0;
        valid_in = 1'b0;
        check("mid_rst_diff", 32'(d1_diff), 32'd0);
        check("mid_rst_valid", 32'(d1_valid), 32'd0);
        check("mid_rst_primed", 32'(d1_primed), 32'd0);
        check("mid_rst_d3_primed", 32'(d3_primed), 32'd0);
        idle();
        check("post_rst_idle", 32'(d1_valid), 32'd0);
        accept(8'd8);
        check("post_rst_d1", 32'(d1_diff), 32'd8);
        check("post_rst_d1_primed", 32'(d1_primed), 32'd1);
        check("post_rst_d3", 32'(d3_diff), 32'd8);
        check("post_rst_d3_primed0", 32'(d3_primed), 32'd0);
        accept(8'd9);
        check("post_rst_d3_primed1", 32'(d3_primed), 32'd0);
        accept(8'd10);
        check("post_rst_d3_val", 32'(d3_diff), 32'd10);
        check("post_rst_d3_primed2", 32'(d3_primed), 32'd1);
        accept(8'd11);
        check("post_rst_d3_wrap", 32'(d3_diff), 32'd3);
        check("post_rst_d1_last", 32'(d1_diff), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_differentiator
